wb_arbiter: RTL

Writeback arbiter between the execution units and the ROB's two result-write ports. It buffers one completed result per functional unit (add, mul, div, mem) and grants up to two per cycle onto wb port 0 and port 1. Both ports are registered and drive the ROB's valid/Pw/exp/tag result inputs. Fairness is round-robin.

---
 rtl/wb_pkg.sv | 26 ++
 rtl/wb_pick2.sv | 69 ++++++
 rtl/wb_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared constants, result packet type and wrap helper for the
// writeback arbiter. Optional age-priority mode is selected by the
// WB_AGE_PRIO_EN macro in the files that import this package.
package wb_pkg;

  localparam int NUM_REQ = 4;
  localparam int TAG_W   = 5;
  localparam int PREG_W  = 5;
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef logic [IDX_W-1:0] idx_t;

  typedef struct packed {
    logic [PREG_W-1:0] Pw;
    logic              exp;
    logic [TAG_W-1:0]  tag;
  } wb_pkt_t;

  // (base + off) mod NUM_REQ, so NUM_REQ need not be a power of two
  function automatic idx_t rot_idx(input idx_t base, input int unsigned off);
    int unsigned sum;
    sum = (32'(base) + off) % NUM_REQ;
    return idx_t'(sum);
  endfunction

endpackage

// File: rtl/wb_pick2.sv
// wb_pick2: combinational find-first-two picker over the occupied slots.
// Default build scans round-robin from a start pointer; with WB_AGE_PRIO_EN
// defined it instead picks the two smallest age keys (ties to lower index).
module wb_pick2
  import wb_pkg::*;
(
  input  logic [NUM_REQ-1:0]            occ_i,
`ifdef WB_AGE_PRIO_EN
  input  logic [NUM_REQ-1:0][TAG_W-1:0] key_i,
`else
  input  idx_t                          start_i,
`endif
  output logic                          g0_v_o,
  output idx_t                          g0_idx_o,
  output logic                          g1_v_o,
  output idx_t                          g1_idx_o
);

`ifdef WB_AGE_PRIO_EN

  // Oldest slot goes to port 0, second oldest to port 1; strict compare keeps ties on the lower index
  always_comb begin
    g0_v_o   = 1'b0;
    g0_idx_o = '0;
    g1_v_o   = 1'b0;
    g1_idx_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (occ_i[i] && (!g0_v_o || (key_i[i] < key_i[g0_idx_o]))) begin
        g0_v_o   = 1'b1;
        g0_idx_o = idx_t'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (occ_i[i] && !(g0_v_o && (g0_idx_o == idx_t'(i))) &&
          (!g1_v_o || (key_i[i] < key_i[g1_idx_o]))) begin
        g1_v_o   = 1'b1;
        g1_idx_o = idx_t'(i);
      end
    end
  end

`else

  idx_t cand;

  // Walk the slots starting at the round-robin pointer; first hit is port 0, second is port 1
  always_comb begin
    g0_v_o   = 1'b0;
    g0_idx_o = '0;
    g1_v_o   = 1'b0;
    g1_idx_o = '0;
    cand     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = rot_idx(start_i, k);
      if (occ_i[cand]) begin
        if (!g0_v_o) begin
          g0_v_o   = 1'b1;
          g0_idx_o = cand;
        end else if (!g1_v_o) begin
          g1_v_o   = 1'b1;
          g1_idx_o = cand;
        end
      end
    end
  end

`endif

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: buffers one completed result per functional unit and grants
// up to two per cycle onto the ROB's registered writeback ports.
// Round-robin fairness by default; defining WB_AGE_PRIO_EN switches to
// oldest-first priority relative to the ROB head pointer ptr_old.
module wb_arbiter
  import wb_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      freeze_back,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*PREG_W-1:0] req_Pw,
  input  logic [NUM_REQ-1:0]        req_exp,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [TAG_W-1:0]          ptr_old,
  output logic                      wb0_valid,
  output logic [PREG_W-1:0]         wb0_Pw,
  output logic                      wb0_exp,
  output logic [TAG_W-1:0]          wb0_tag,
  output logic                      wb1_valid,
  output logic [PREG_W-1:0]         wb1_Pw,
  output logic                      wb1_exp,
  output logic [TAG_W-1:0]          wb1_tag,
  output logic                      busy
);

  logic [NUM_REQ-1:0]    slotValid_q, slotValid_d;
  wb_pkt_t [NUM_REQ-1:0] slotPkt_q, slotPkt_d;
  logic                  wb0Valid_q, wb0Valid_d, wb1Valid_q, wb1Valid_d;
  wb_pkt_t               wb0Pkt_q, wb0Pkt_d, wb1Pkt_q, wb1Pkt_d;

  logic [NUM_REQ-1:0]    occEff, granted, accept;
  logic                  g0V, g1V;
  idx_t                  g0Idx, g1Idx;

  // A frozen back end sees no occupied slots, so no grants are produced
  assign occEff = freeze_back ? '0 : slotValid_q;

`ifdef WB_AGE_PRIO_EN

  logic [NUM_REQ-1:0][TAG_W-1:0] ageKey;

  // Age key is distance from the ROB head, modulo the tag space
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      ageKey[i] = slotPkt_q[i].tag - ptr_old;
    end
  end

  wb_pick2 u_pick (
    .occ_i    (occEff),
    .key_i    (ageKey),
    .g0_v_o   (g0V),
    .g0_idx_o (g0Idx),
    .g1_v_o   (g1V),
    .g1_idx_o (g1Idx)
  );

`else

  idx_t rrPtr_q, rrPtr_d;
  logic unused_ptr_old;

  assign unused_ptr_old = ^ptr_old;

  wb_pick2 u_pick (
    .occ_i    (occEff),
    .start_i  (rrPtr_q),
    .g0_v_o   (g0V),
    .g0_idx_o (g0Idx),
    .g1_v_o   (g1V),
    .g1_idx_o (g1Idx)
  );

  // Pointer moves one past the last slot granted this cycle; flush rewinds it
  always_comb begin
    rrPtr_d = rrPtr_q;
    if (g1V) begin
      rrPtr_d = rot_idx(g1Idx, 1);
    end else if (g0V) begin
      rrPtr_d = rot_idx(g0Idx, 1);
    end
    if (flush) begin
      rrPtr_d = '0;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rrPtr_q <= '0;
    end else begin
      rrPtr_q <= rrPtr_d;
    end
  end

`endif

  // One-hot view of which slots are being drained this cycle
  always_comb begin
    granted = '0;
    if (g0V) granted[g0Idx] = 1'b1;
    if (g1V) granted[g1Idx] = 1'b1;
  end

  assign req_ready = {NUM_REQ{!flush}} & (~slotValid_q | granted);
  assign accept    = req_valid & req_ready;

  // Slot refill wins over drain so a granted slot can take a new result in the same cycle
  always_comb begin
    slotValid_d = slotValid_q;
    slotPkt_d   = slotPkt_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept[i]) begin
        slotValid_d[i] = 1'b1;
        slotPkt_d[i]   = '{Pw:  req_Pw[i*PREG_W +: PREG_W],
                           exp: req_exp[i],
                           tag: req_tag[i*TAG_W +: TAG_W]};
      end else if (granted[i]) begin
        slotValid_d[i] = 1'b0;
      end
    end
    if (flush) begin
      slotValid_d = '0;
    end
  end

  // Port registers load the granted packets unless frozen, where they hold for an idempotent re-present
  always_comb begin
    wb0Valid_d = wb0Valid_q;
    wb0Pkt_d   = wb0Pkt_q;
    wb1Valid_d = wb1Valid_q;
    wb1Pkt_d   = wb1Pkt_q;
    if (!freeze_back) begin
      wb0Valid_d = g0V;
      wb1Valid_d = g1V;
      if (g0V) wb0Pkt_d = slotPkt_q[g0Idx];
      if (g1V) wb1Pkt_d = slotPkt_q[g1Idx];
    end
    if (flush) begin
      wb0Valid_d = 1'b0;
      wb1Valid_d = 1'b0;
    end
  end

  // Slot and port state, cleared immediately by the active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slotValid_q <= '0;
      slotPkt_q   <= '0;
      wb0Valid_q  <= 1'b0;
      wb0Pkt_q    <= '0;
      wb1Valid_q  <= 1'b0;
      wb1Pkt_q    <= '0;
    end else begin
      slotValid_q <= slotValid_d;
      slotPkt_q   <= slotPkt_d;
      wb0Valid_q  <= wb0Valid_d;
      wb0Pkt_q    <= wb0Pkt_d;
      wb1Valid_q  <= wb1Valid_d;
      wb1Pkt_q    <= wb1Pkt_d;
    end
  end

  assign wb0_valid = wb0Valid_q;
  assign wb0_Pw    = wb0Pkt_q.Pw;
  assign wb0_exp   = wb0Pkt_q.exp;
  assign wb0_tag   = wb0Pkt_q.tag;
  assign wb1_valid = wb1Valid_q;
  assign wb1_Pw    = wb1Pkt_q.Pw;
  assign wb1_exp   = wb1Pkt_q.exp;
  assign wb1_tag   = wb1Pkt_q.tag;
  assign busy      = (|slotValid_q) | wb0Valid_q | wb1Valid_q;

endmodule
